// File: rtl/firout.sv
// Output conditioning after the last FIR tap: decimate, round-half-up right shift,
// saturate to YW bits, and buffer behind a valid/ready FIFO with sticky ovf/drop flags.
module firout #(
    parameter int OUTW  = 48,
    parameter int YW    = 16,
    parameter int SHW   = 6,
    parameter int DECW  = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [OUTW-1:0]   in_sum,
    input  logic [SHW-1:0]    shift,
    input  logic [DECW-1:0]   dec,
    output logic              out_valid,
    output logic [YW-1:0]     out_y,
    input  logic              out_ready,
    output logic              ovf,
    output logic              drop,
    input  logic              flag_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [OUTW:0] YMAX = {{(OUTW-YW+2){1'b0}}, {(YW-1){1'b1}}};
    localparam logic signed [OUTW:0] YMIN = {{(OUTW-YW+2){1'b1}}, {(YW-1){1'b0}}};

    logic [DECW-1:0]         cnt_r;
    logic                    s1_valid_r;
    logic signed [OUTW-1:0]  s1_sum_r;
    logic [SHW-1:0]          sh_s;
    logic signed [OUTW:0]    ext_s;
    logic signed [OUTW:0]    half_s;
    logic signed [OUTW:0]    rnd_s;
    logic                    s2_valid_r;
    logic signed [OUTW:0]    s2_r;
    logic [YW-1:0]           sat_s;
    logic                    clamp_s;
    logic [YW-1:0]           mem_r [DEPTH];
    logic [AW:0]             wr_ptr_r;
    logic [AW:0]             rd_ptr_r;
    logic [AW:0]             wr_ptr_nx_s;
    logic [AW:0]             rd_ptr_nx_s;
    logic                    full_s;
    logic                    empty_nx_s;
    logic                    rd_en_s;
    logic                    wr_en_s;
    logic [YW-1:0]           head_nx_s;
    logic                    out_valid_r;
    logic [YW-1:0]           out_y_r;
    logic                    ovf_r;
    logic                    drop_r;

    // Stage 1: decimation counter; the sample seen while cnt is zero is kept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r      <= {DECW{1'b0}};
            s1_valid_r <= 1'b0;
            s1_sum_r   <= {OUTW{1'b0}};
        end else begin
            s1_valid_r <= in_valid && (cnt_r == {DECW{1'b0}});
            if (in_valid) begin
                if (cnt_r >= dec) begin
                    cnt_r <= {DECW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + {{(DECW-1){1'b0}}, 1'b1};
                end
                if (cnt_r == {DECW{1'b0}}) begin
                    s1_sum_r <= in_sum;
                end
            end
        end
    end

    // Stage 2 datapath: clamp the shift, add the half-LSB and shift one bit wider so the add cannot wrap
    always_comb begin
        sh_s = shift;
        if ({{(32-SHW){1'b0}}, shift} >= OUTW) begin
            sh_s = SHW'(OUTW - 1);
        end else begin
            sh_s = shift;
        end
        ext_s = {s1_sum_r[OUTW-1], s1_sum_r};
        if (sh_s == {SHW{1'b0}}) begin
            half_s = {(OUTW+1){1'b0}};
        end else begin
            half_s = {{OUTW{1'b0}}, 1'b1} << (sh_s - {{(SHW-1){1'b0}}, 1'b1});
        end
        rnd_s = (ext_s + half_s) >>> sh_s;
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_r <= 1'b0;
            s2_r       <= {(OUTW+1){1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_r <= rnd_s;
            end
        end
    end

    // Stage 3: saturate to the output width, feeding the FIFO write in the same cycle
    always_comb begin
        sat_s   = s2_r[YW-1:0];
        clamp_s = 1'b0;
        if (s2_r > YMAX) begin
            sat_s   = {1'b0, {(YW-1){1'b1}}};
            clamp_s = 1'b1;
        end else if (s2_r < YMIN) begin
            sat_s   = {1'b1, {(YW-1){1'b0}}};
            clamp_s = 1'b1;
        end else begin
            sat_s   = s2_r[YW-1:0];
            clamp_s = 1'b0;
        end
    end

    // FIFO control; the next head bypasses from the write data when it lands in an empty slot
    always_comb begin
        rd_en_s     = out_valid_r && out_ready;
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_en_s     = s2_valid_r && (!full_s || rd_en_s);
        rd_ptr_nx_s = rd_en_s ? rd_ptr_r + {{AW{1'b0}}, 1'b1} : rd_ptr_r;
        wr_ptr_nx_s = wr_en_s ? wr_ptr_r + {{AW{1'b0}}, 1'b1} : wr_ptr_r;
        empty_nx_s  = (rd_ptr_nx_s == wr_ptr_nx_s);
        if (wr_en_s && (rd_ptr_nx_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
            head_nx_s = sat_s;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s[AW-1:0]];
        end
    end

    // FIFO storage, pointers and registered head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {YW{1'b0}};
            end
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
            out_y_r     <= {YW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= sat_s;
            end
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            out_valid_r <= !empty_nx_s;
            if (!empty_nx_s) begin
                out_y_r <= head_nx_s;
            end
        end
    end

    // Sticky flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_r  <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            if (s2_valid_r && clamp_s) begin
                ovf_r <= 1'b1;
            end else if (flag_clr) begin
                ovf_r <= 1'b0;
            end
            if (s2_valid_r && !wr_en_s) begin
                drop_r <= 1'b1;
            end else if (flag_clr) begin
                drop_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_y     = out_y_r;
    assign ovf       = ovf_r;
    assign drop      = drop_r;

endmodule

// File: tb/tb_firout.sv
// Scoreboard bench for firout: an arithmetic reference model predicts each kept sample,
// a queue-level FIFO model predicts drops and flags, and a monitor compares every output.
module tb_firout;
    localparam int OUTW  = 48;
    localparam int YW    = 16;
    localparam int SHW   = 6;
    localparam int DECW  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic [OUTW-1:0] in_sum = '0;
    logic [SHW-1:0]  shift = '0;
    logic [DECW-1:0] dec = '0;
    logic            out_ready = 1'b1;
    logic            flag_clr = 1'b0;
    logic            out_valid;
    logic [YW-1:0]   out_y;
    logic            ovf;
    logic            drop;

    firout #(.OUTW(OUTW), .YW(YW), .SHW(SHW), .DECW(DECW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sum(in_sum), .shift(shift),
        .dec(dec), .out_valid(out_valid), .out_y(out_y), .out_ready(out_ready),
        .ovf(ovf), .drop(drop), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int y; bit sat;} pend_t;
    pend_t pend_q[$];
    int    exp_q[$];
    int    got_q[$];
    int    want_q[$];
    int    mocc = 0;
    int    mcnt = 0;
    int    cyc = 0;
    bit    m_ovf = 1'b0;
    bit    m_drop = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // reference: round-half-up arithmetic shift, then clamp to the signed output range
    function automatic void ref_y(input longint x, input int sh, output int y, output bit sat);
        int     s;
        longint one;
        longint r;
        one = 1;
        s   = (sh >= OUTW) ? OUTW - 1 : sh;
        r   = (s > 0) ? ((x + (one << (s - 1))) >>> s) : x;
        sat = 1'b1;
        if (r > 32767) y = 32767;
        else if (r < -32768) y = -32768;
        else begin
            y   = int'(r);
            sat = 1'b0;
        end
    endfunction

    // model: decimation, FIFO occupancy, drops and sticky flags, evaluated per clock edge
    initial begin
        bit    rd;
        bit    s_ovf;
        bit    s_drop;
        int    y;
        bit    sat;
        pend_t it;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                pend_q.delete();
                exp_q.delete();
                mocc = 0; mcnt = 0; cyc = 0; m_ovf = 1'b0; m_drop = 1'b0;
            end else begin
                rd = (mocc > 0) && out_ready;
                s_ovf = 1'b0;
                s_drop = 1'b0;
                while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    it = pend_q.pop_front();
                    if (it.sat) s_ovf = 1'b1;
                    if (mocc < DEPTH || rd) begin
                        exp_q.push_back(it.y);
                        mocc++;
                    end else begin
                        s_drop = 1'b1;
                    end
                end
                if (rd) mocc--;
                m_ovf  = s_ovf  ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
                m_drop = s_drop ? 1'b1 : (flag_clr ? 1'b0 : m_drop);
                if (in_valid) begin
                    if (mcnt == 0) begin
                        ref_y(longint'($signed(in_sum)), int'(shift), y, sat);
                        pend_q.push_back('{cyc + 2, y, sat});
                    end
                    mcnt = (mcnt >= int'(dec)) ? 0 : mcnt + 1;
                end
                cyc++;
            end
        end
    end

    // monitor: compare the presented head and flags mid-cycle, pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("out_valid", out_valid, (mocc > 0) ? 1 : 0);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        chk("out_y", $signed(out_y), exp_q[0]);
                        if (out_ready) begin
                            got_q.push_back(int'($signed(out_y)));
                            void'(exp_q.pop_front());
                        end
                    end
                end
                chk("ovf", ovf, m_ovf);
                chk("drop", drop, m_drop);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input longint x);
        in_valid = 1'b1;
        in_sum   = OUTW'(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
    endtask

    task automatic check_seq(input string name);
        chk({name, "_count"}, got_q.size(), want_q.size());
        for (int i = 0; i < want_q.size() && i < got_q.size(); i++) begin
            chk(name, got_q[i], want_q[i]);
        end
        got_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_y"}, out_y, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_drop"}, drop, 0);
    endtask

    task automatic rand_sum(output logic [OUTW-1:0] v);
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0: v = OUTW'(longint'($urandom_range(0, 100000)) - 64'sd50000);
            1: v = w[OUTW-1:0];
            default: v = OUTW'(longint'($signed(w[23:0])));
        endcase
    endtask

    initial begin
        int shs [8] = '{0, 3, 4, 9, 15, 20, 47, 63};
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rstn = 1'b1;
        idle(1);

        got_q.delete();
        drive(5); drive(-7); drive(32767); drive(-32768);
        idle(6);
        want_q = '{5, -7, 32767, -32768};
        check_seq("passthrough");

        shift = 6'd4;
        idle(1);
        drive(24); drive(23); drive(-24); drive(-25);
        idle(3);
        shift = 6'd63;
        idle(1);
        drive(-1);
        idle(6);
        want_q = '{2, 1, -1, -2, 0};
        check_seq("round_shift");

        shift = 6'd0;
        idle(2);
        drive(40000); drive(-40000);
        idle(6);
        want_q = '{32767, -32768};
        check_seq("saturate");
        chk("ovf_after_sat", ovf, 1);
        pulse_clr();
        idle(1);
        chk("ovf_after_clr", ovf, 0);
        drive(40000);
        idle(1);
        pulse_clr();
        #1;
        chk("ovf_clr_coincident", ovf, 1);
        idle(5);
        got_q.delete();

        dec = 8'd2;
        for (int i = 0; i < 9; i++) drive(i);
        idle(6);
        want_q = '{0, 3, 6};
        check_seq("decimate");
        dec = 8'd5;
        drive(100); drive(101); drive(102);
        dec = 8'd1;
        drive(103); drive(104); drive(105); drive(106);
        idle(6);
        want_q = '{100, 104, 106};
        check_seq("dec_change");
        dec = 8'd0;
        drive(0);
        idle(4);
        got_q.delete();

        pulse_clr();
        out_ready = 1'b0;
        for (int i = 11; i <= 15; i++) drive(i);
        idle(1);
        out_ready = 1'b1;
        idle(8);
        chk("no_drop_full_with_read", drop, 0);
        want_q = '{11, 12, 13, 14, 15};
        check_seq("write_while_full");

        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) drive(i);
        idle(4);
        chk("overrun_drop", drop, 1);
        chk("overrun_hold", out_y, 1);
        out_ready = 1'b1;
        idle(6);
        want_q = '{1, 2, 3, 4};
        check_seq("overrun_drain");

        out_ready = 1'b0;
        drive(40000); drive(2); drive(3);
        idle(5);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset("async_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        dec = 8'd3;
        got_q.delete();
        drive(9);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_latency_valid", out_valid, 1);
        chk("post_reset_latency_y", $signed(out_y), 9);
        idle(3);
        want_q = '{9};
        check_seq("post_reset");

        for (int b = 0; b < 8; b++) begin
            shift = SHW'(shs[b]);
            dec   = DECW'($urandom_range(0, 3));
            idle(1);
            for (int c = 0; c < 60; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                rand_sum(in_sum);
                out_ready = ($urandom_range(0, 2) != 0);
                flag_clr  = ($urandom_range(0, 15) == 0);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            flag_clr = 1'b0;
            idle(3);
        end
        out_ready = 1'b1;
        idle(10);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
